// File: rtl/decoder_scan.sv
// decoder_scan: N-to-2^N one-hot decoder with registered outputs.
// Direct mode decodes A. Scan mode steps through the lines, holding each for DWELL cycles.
// Optional line mask with skip-scan: define DECODER_SCAN_SKIP_EN.
module decoder_scan #(
  parameter int unsigned N          = 3,
  parameter int unsigned DWELL      = 4,
  parameter bit          ACTIVE_LOW = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                E,
  input  logic                mode,
  input  logic [N-1:0]        A,
`ifdef DECODER_SCAN_SKIP_EN
  input  logic [(2**N)-1:0]   mask,
`endif
  output logic [(2**N)-1:0]   S,
  output logic [N-1:0]        idx,
  output logic                wrap
);

  localparam int unsigned OUT_W = 2 ** N;
  localparam int unsigned CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);
  localparam logic [OUT_W-1:0] S_OFF    = {OUT_W{ACTIVE_LOW}};
  localparam logic [OUT_W-1:0] POL      = {OUT_W{ACTIVE_LOW}};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DIRECT,
    ST_SCAN
  } state_t;

  state_t           state_q, state_d;
  logic [OUT_W-1:0] s_q, s_d;
  logic [N-1:0]     idx_q, idx_d;
  logic             wrap_q, wrap_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [OUT_W-1:0] en_mask;
  logic             any_en;
  logic [N-1:0]     low_idx;
  logic [N-1:0]     nxt_idx;
  logic [N-1:0]     cand;

`ifdef DECODER_SCAN_SKIP_EN
  assign en_mask = mask;
`else
  assign en_mask = {OUT_W{1'b1}};
`endif

  assign any_en = |en_mask;

  // Lowest enabled line and next enabled line above idx (wrapping); idx itself if it is the only one
  always_comb begin
    low_idx = '0;
    nxt_idx = idx_q;
    cand    = idx_q;
    for (int k = int'(OUT_W) - 1; k >= 0; k--) begin
      if (en_mask[N'(k)]) low_idx = N'(k);
    end
    for (int k = int'(OUT_W); k >= 1; k--) begin
      cand = idx_q + N'(k);
      if (en_mask[cand]) nxt_idx = cand;
    end
  end

  // Next state and next registered outputs
  always_comb begin
    state_d = state_q;
    s_d     = S_OFF;
    idx_d   = idx_q;
    wrap_d  = 1'b0;
    cnt_d   = '0;

    if (!E)         state_d = ST_IDLE;
    else if (!mode) state_d = ST_DIRECT;
    else            state_d = ST_SCAN;

    case (state_d)
      ST_DIRECT: begin
        idx_d = A;
        s_d   = ((OUT_W'(1) << A) & en_mask) ^ POL;
      end
      ST_SCAN: begin
        if (state_q != ST_SCAN) begin
          // Entry: restart at the first enabled line, no wrap pulse
          if (any_en) begin
            idx_d = low_idx;
            s_d   = (OUT_W'(1) << low_idx) ^ POL;
          end
        end else if (cnt_q == CNT_LAST) begin
          if (any_en) begin
            idx_d  = nxt_idx;
            s_d    = (OUT_W'(1) << nxt_idx) ^ POL;
            wrap_d = (nxt_idx <= idx_q);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          s_d   = ((OUT_W'(1) << idx_q) & en_mask) ^ POL;
        end
      end
      default: begin
        // Idle: lines off, idx holds
      end
    endcase
  end

  // State and output registers, synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      s_q     <= S_OFF;
      idx_q   <= '0;
      wrap_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      idx_q   <= idx_d;
      wrap_q  <= wrap_d;
      cnt_q   <= cnt_d;
    end
  end

  assign S    = s_q;
  assign idx  = idx_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_decoder_scan.sv
// Bench for decoder_scan: two instances (DWELL=4 active-high, DWELL=1 active-low)
// share stimulus and are checked every cycle against a behavioural model through a scoreboard.
module tb_decoder_scan;

  logic       clk = 1'b0;
  logic       rst;
  logic       E;
  logic       mode;
  logic [2:0] A;
  logic [7:0] mask;

  logic [7:0] s_a, s_b;
  logic [2:0] idx_a, idx_b;
  logic       wrap_a, wrap_b;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  decoder_scan #(.N(3), .DWELL(4), .ACTIVE_LOW(1'b0)) u_dut_a (
    .clk  (clk),
    .rst  (rst),
    .E    (E),
    .mode (mode),
    .A    (A),
`ifdef DECODER_SCAN_SKIP_EN
    .mask (mask),
`endif
    .S    (s_a),
    .idx  (idx_a),
    .wrap (wrap_a)
  );

  decoder_scan #(.N(3), .DWELL(1), .ACTIVE_LOW(1'b1)) u_dut_b (
    .clk  (clk),
    .rst  (rst),
    .E    (E),
    .mode (mode),
    .A    (A),
`ifdef DECODER_SCAN_SKIP_EN
    .mask (mask),
`endif
    .S    (s_b),
    .idx  (idx_b),
    .wrap (wrap_b)
  );

  typedef struct packed {
    logic [7:0] s_a;
    logic [7:0] s_b;
    logic [2:0] i_a;
    logic [2:0] i_b;
    logic       w_a;
    logic       w_b;
  } exp_t;

  exp_t sb_q[$];

  // Model state per instance: 0 idle, 1 direct, 2 scan
  int m_state[2] = '{0, 0};
  int m_idx[2]   = '{0, 0};
  int m_cnt[2]   = '{0, 0};
  bit m_on[2]    = '{1'b0, 1'b0};
  bit m_wrap[2]  = '{1'b0, 1'b0};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] eff_mask();
`ifdef DECODER_SCAN_SKIP_EN
    return mask;
`else
    return 8'hFF;
`endif
  endfunction

  task automatic model_step(input int i);
    logic [7:0] mk;
    int p;
    int dw;
    mk = eff_mask();
    dw = (i == 0) ? 4 : 1;
    if (rst) begin
      m_state[i] = 0; m_idx[i] = 0; m_cnt[i] = 0; m_on[i] = 1'b0; m_wrap[i] = 1'b0;
    end else if (!E) begin
      m_state[i] = 0; m_cnt[i] = 0; m_on[i] = 1'b0; m_wrap[i] = 1'b0;
    end else if (!mode) begin
      m_state[i] = 1; m_idx[i] = int'(A); m_cnt[i] = 0; m_on[i] = mk[A]; m_wrap[i] = 1'b0;
    end else if (m_state[i] != 2) begin
      m_state[i] = 2; m_cnt[i] = 0; m_wrap[i] = 1'b0; m_on[i] = 1'b0;
      for (int j = 7; j >= 0; j--) begin
        if (mk[j]) begin
          m_idx[i] = j;
          m_on[i]  = 1'b1;
        end
      end
    end else begin
      m_wrap[i] = 1'b0;
      if (m_cnt[i] == dw - 1) begin
        m_cnt[i] = 0;
        if (mk != 8'h00) begin
          p = m_idx[i];
          do m_idx[i] = (m_idx[i] + 1) % 8; while (!mk[m_idx[i]]);
          m_on[i]   = 1'b1;
          m_wrap[i] = (m_idx[i] <= p);
        end else begin
          m_on[i] = 1'b0;
        end
      end else begin
        m_cnt[i]++;
        m_on[i] = mk[m_idx[i]];
      end
    end
  endtask

  function automatic logic [7:0] exp_s(input int i);
    logic [7:0] v;
    v = m_on[i] ? (8'h01 << m_idx[i]) : 8'h00;
    if (i == 1) v = ~v;
    return v;
  endfunction

  // One clock: predict, push, clock, pop and compare
  task automatic tick();
    exp_t e;
    model_step(0);
    model_step(1);
    e.s_a = exp_s(0);
    e.s_b = exp_s(1);
    e.i_a = 3'(m_idx[0]);
    e.i_b = 3'(m_idx[1]);
    e.w_a = m_wrap[0];
    e.w_b = m_wrap[1];
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      check("S_a",    32'(s_a),    32'(e.s_a));
      check("S_b",    32'(s_b),    32'(e.s_b));
      check("idx_a",  32'(idx_a),  32'(e.i_a));
      check("idx_b",  32'(idx_b),  32'(e.i_b));
      check("wrap_a", 32'(wrap_a), 32'(e.w_a));
      check("wrap_b", 32'(wrap_b), 32'(e.w_b));
    end
  endtask

  initial begin
    logic [7:0] one;
    one  = 8'h01;
    rst  = 1'b1;
    E    = 1'b1;
    mode = 1'b1;
    A    = 3'd0;
    mask = 8'hFF;

    // Reset with E=1, mode=1
    tick();
    tick();
    check("rst_S_a",   32'(s_a),   32'h00);
    check("rst_S_b",   32'(s_b),   32'hFF);
    check("rst_idx_a", 32'(idx_a), 32'd0);
    check("rst_wrap_a", 32'(wrap_a), 32'd0);
    rst = 1'b0;

    // Direct decode of every address
    mode = 1'b0;
    for (int a = 0; a < 8; a++) begin
      A = 3'(a);
      tick();
      check("direct_S_a", 32'(s_a), 32'(one << a));
      tick();
    end
    E = 1'b0;
    A = 3'd4;
    tick();
    check("disable_S_a", 32'(s_a), 32'h00);

    // Scan with DWELL=4: wrap only on the return to line 0 at cycle 32
    E    = 1'b1;
    mode = 1'b1;
    for (int k = 0; k < 40; k++) begin
      tick();
      check("scan_wrap_pos", 32'(wrap_a), 32'(k == 32));
      check("scan_idx_a",    32'(idx_a),  32'((k / 4) % 8));
    end

    // DWELL=1 instance: scan to idx 5, switch to direct, back to scan
    E = 1'b0;
    tick();
    E = 1'b1;
    repeat (6) tick();
    check("dw1_idx5", 32'(idx_b), 32'd5);
    mode = 1'b0;
    A    = 3'd2;
    tick();
    check("dw1_direct_S", 32'(s_b), 32'hFB);
    mode = 1'b1;
    tick();
    check("dw1_reentry_S",    32'(s_b),    32'hFE);
    check("dw1_reentry_idx",  32'(idx_b),  32'd0);
    check("dw1_reentry_wrap", 32'(wrap_b), 32'd0);

    // DWELL=4 instance entered scan on the last edge; reach idx 6, counter 2
    repeat (26) tick();
    check("pre_rst_idx_a", 32'(idx_a), 32'd6);
    rst = 1'b1;
    tick();
    check("midrst_S_a",   32'(s_a),   32'h00);
    check("midrst_idx_a", 32'(idx_a), 32'd0);
    check("midrst_S_b",   32'(s_b),   32'hFF);
    rst = 1'b0;
    tick();
    check("post_rst_S_a", 32'(s_a), 32'h01);
    check("post_rst_S_b", 32'(s_b), 32'hFE);

`ifdef DECODER_SCAN_SKIP_EN
    // Skip scan over a sparse mask, then an empty mask
    E = 1'b0;
    tick();
    E    = 1'b1;
    mask = 8'b1010_0100;
    tick();
    check("skip_entry_S_a", 32'(s_a), 32'h04);
    repeat (20) tick();
    mask = 8'h00;
    repeat (6) tick();
    check("skip_zero_S_a", 32'(s_a), 32'h00);
    mask = 8'h10;
    repeat (10) tick();
    mask = 8'hFF;
`endif

    // Random traffic
    for (int k = 0; k < 300; k++) begin
      rst  = ($urandom_range(0, 31) == 0);
      E    = ($urandom_range(0, 7) != 0);
      mode = ($urandom_range(0, 3) != 0);
      A    = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 15) == 0) begin
        case ($urandom_range(0, 2))
          0:       mask = 8'h00;
          1:       mask = 8'h01 << $urandom_range(0, 7);
          default: mask = 8'($urandom_range(0, 255));
        endcase
      end
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
